hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage miniRV core (IF/ID/EX/MEM/WB).
- Keeps its own shadow shift register of in-flight destination info for EX, MEM and WB.
- Generates forwarding selects into ID, load-use stalls, redirect flushes and memory-wait freezes.
- Drives stall/flush enables of every pipeline register. Sits beside the decode/SEXT logic in ID.

Parameters:
CNT_W, 16, width of the saturating stall and flush performance counters.
NREG, 32, architectural register count; register index width is clog2(NREG).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  source 1 index
id_rs2  in  5  source 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  5  destination index
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
dmem_busy  in  1  data memory not ready; whole pipe must hold
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to bubble
idex_flush  out  1  load bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
fwd_rs1  out  2  forward select for rs1 (FWD_RF/FWD_EX/FWD_MEM/FWD_WB)
fwd_rs2  out  2  forward select for rs2
stall_cnt  out  CNT_W  cycles lost to data stalls
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Shadow stages S_EX, S_MEM, S_WB each hold {v, rd, we, ld}. Reset: all fields 0, both counters 0.
- All outputs are 0 while rst is asserted and in the first cycle after reset.
- A stage matches a source when: v=1, we=1, rd!=0, rd==rs, and the matching rsN_used=1.
- Forward select, youngest match wins: S_EX hit -> FWD_EX; else S_MEM -> FWD_MEM; else S_WB -> FWD_WB; else FWD_RF.
- x0 is never forwarded.
- Load-use: a match against S_EX with ld=1 gives data_stall=1. Actions: pc_stall=1, ifid_stall=1, idex_flush=1. The forward select for that source is don't-care.
- Redirect: ex_redirect=1 gives ifid_flush=1 and idex_flush=1, 1-cycle pulse.
  - Redirect overrides data_stall: pc_stall=0 and ifid_stall=0, so the PC loads the target.
  - data_stall is not counted in that cycle.
- Memory wait: dmem_busy=1 gives pipe_freeze=1, pc_stall=1, ifid_stall=1.
  - Flush outputs are forced to 0 and the shadow does not shift.
  - dmem_busy has highest priority. A redirect arriving under dmem_busy is held by EX and reasserted by it once the stall clears; this block does not latch it.
- Shadow shift when not frozen:
  - S_WB <= S_MEM, S_MEM <= S_EX.
  - S_EX <= {id_valid, id_rd, id_we, id_is_load}, or all-zero when idex_flush=1.
- stall_cnt increments on each cycle with data_stall=1, no redirect and no dmem_busy.
- flush_cnt increments on each unfrozen ex_redirect cycle.
- Both counters saturate at all-ones and are cleared only by rst.
- rst mid-stall: the shadow clears immediately; the next cycle has no stall or forward.

Optional Feature:
- Macro FORWARD_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_rs1 and fwd_rs2 are tied to FWD_RF.
  - data_stall=1 on any match in S_EX, S_MEM or S_WB, regardless of ld. The regfile writes at the end of WB and is not write-through.
  - stall_cnt counts these cycles.

Decomposition:
- Shared package/defines header holds:
  - FWD_RF=2'd0, FWD_EX=2'd1, FWD_MEM=2'd2, FWD_WB=2'd3
  - shadow-stage field widths
  - FORWARD_EN guard
- One sub-module, hazard_match: pure compare of one source against three shadow stages. Outputs hit_ex, hit_mem, hit_wb and ld_ex. Instantiated twice (rs1, rs2).
- The FSM-free shift/counter logic stays in hazard_ctrl.

Test Plan:
- ALU producer then consumer: add x5 (we=1), next id_rs1=5 -> cycle 2 fwd_rs1=FWD_EX; one cycle later with a gap instr fwd_rs1=FWD_MEM; stall_cnt stays 0.
- Load-use: lw x7, then id_rs2=7 -> exactly 1 cycle pc_stall=ifid_stall=idex_flush=1, next cycle fwd_rs2=FWD_MEM, stall_cnt=1.
- x0 and unused source: producer rd=0, or rs1_used=0 with rs1 matching -> fwd=FWD_RF, no stall.
- Redirect during load-use: ex_redirect=1 same cycle as data_stall -> ifid_flush=idex_flush=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- dmem_busy held 3 cycles with load in S_EX -> pipe_freeze=1 for 3 cycles, shadow unchanged, no flush pulse. After release the stall resolves as normal.
- Compile without FORWARD_EN: producer x3 then consumer x3 -> 3 stall cycles (EX/MEM/WB matches), fwd always FWD_RF, stall_cnt=3. Also force 2^CNT_W stalls -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the miniRV hazard controller: forward-select
// encodings, shadow-stage field layout and the FORWARD_EN build switch.
// Build option: define FORWARD_EN to enable EX/MEM/WB forwarding; without
// it every in-flight RAW hazard stalls until the producer leaves WB.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Shadow-stage fields: valid, destination index, write enable, load flag.
    localparam int V_W    = 1;
    localparam int REG_W  = 5;
    localparam int WE_W   = 1;
    localparam int LD_W   = 1;
    localparam int SH_W   = V_W + REG_W + WE_W + LD_W;
    // Compare tag {v, rd, we}: everything a match needs except the load flag.
    localparam int TAG_W  = V_W + REG_W + WE_W;

`ifdef FORWARD_EN
    localparam bit FORWARD_ON = 1'b1;
`else
    localparam bit FORWARD_ON = 1'b0;
`endif

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } shadow_t;

    // Youngest producer wins.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem,
                                            input logic hit_wb);
        if (hit_ex)       return FWD_EX;
        else if (hit_mem) return FWD_MEM;
        else if (hit_wb)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Pure combinational compare of one ID source register against the three
// shadow stages. x0 and unused sources never match.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  logic [TAG_W-1:0] ex_tag,
    input  logic             ex_ld,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             hit_ex,
    output logic             hit_mem,
    output logic             hit_wb,
    output logic             ld_ex
);

    function automatic logic tag_hit(input logic [TAG_W-1:0] t,
                                     input logic [REG_W-1:0] r,
                                     input logic u);
        logic             v;
        logic             we;
        logic [REG_W-1:0] rd;
        v  = t[TAG_W-1];
        rd = t[REG_W:1];
        we = t[0];
        return u && v && we && (rd != '0) && (rd == r);
    endfunction

    assign hit_ex  = tag_hit(ex_tag,  rs, used);
    assign hit_mem = tag_hit(mem_tag, rs, used);
    assign hit_wb  = tag_hit(wb_tag,  rs, used);
    assign ld_ex   = hit_ex & ex_ld;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage miniRV core.
// Tracks in-flight destinations in a private EX/MEM/WB shadow, produces
// forward selects, load-use stalls, redirect flushes and memory-wait freezes,
// and counts lost stall cycles and redirect events (saturating).
// Build option: FORWARD_EN (see hazard_ctrl_pkg).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NREG  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  id_rs1,
    input  logic [$clog2(NREG)-1:0]  id_rs2,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [$clog2(NREG)-1:0]  id_rd,
    input  logic                     id_we,
    input  logic                     id_is_load,
    input  logic                     ex_redirect,
    input  logic                     dmem_busy,
    output logic                     pc_stall,
    output logic                     ifid_stall,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic                     pipe_freeze,
    output logic [1:0]               fwd_rs1,
    output logic [1:0]               fwd_rs2,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    // The load flag only matters while the producer sits in EX, so MEM and
    // WB keep just the compare tag.
    shadow_t          s_ex;
    logic [TAG_W-1:0] s_mem;
    logic [TAG_W-1:0] s_wb;
    logic [TAG_W-1:0] ex_tag;

    logic init_q;
    logic active;
    logic busy;
    logic redir;
    logic data_stall;

    logic h1_ex, h1_mem, h1_wb, l1_ex;
    logic h2_ex, h2_mem, h2_wb, l2_ex;
    logic [1:0] sel1, sel2;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign ex_tag = {s_ex.v, s_ex.rd, s_ex.we};

    hazard_match u_match_rs1 (
        .rs      (id_rs1),
        .used    (id_rs1_used),
        .ex_tag  (ex_tag),
        .ex_ld   (s_ex.ld),
        .mem_tag (s_mem),
        .wb_tag  (s_wb),
        .hit_ex  (h1_ex),
        .hit_mem (h1_mem),
        .hit_wb  (h1_wb),
        .ld_ex   (l1_ex)
    );

    hazard_match u_match_rs2 (
        .rs      (id_rs2),
        .used    (id_rs2_used),
        .ex_tag  (ex_tag),
        .ex_ld   (s_ex.ld),
        .mem_tag (s_mem),
        .wb_tag  (s_wb),
        .hit_ex  (h2_ex),
        .hit_mem (h2_mem),
        .hit_wb  (h2_wb),
        .ld_ex   (l2_ex)
    );

    // All outputs stay quiet during reset and for one cycle afterwards.
    assign active = !rst && !init_q;
    assign busy   = active && dmem_busy;
    assign redir  = active && ex_redirect;

`ifdef FORWARD_EN
    // Only a load still in EX cannot be bypassed in time.
    assign data_stall = active && (l1_ex || l2_ex);
    assign sel1       = fwd_pick(h1_ex, h1_mem, h1_wb);
    assign sel2       = fwd_pick(h2_ex, h2_mem, h2_wb);
`else
    // No bypass and no write-through regfile: wait until the producer retires.
    assign data_stall = active && (h1_ex || h1_mem || h1_wb || l1_ex ||
                                   h2_ex || h2_mem || h2_wb || l2_ex);
    assign sel1       = FWD_RF;
    assign sel2       = FWD_RF;
`endif

    // Flag the first cycle after reset so outputs can be held low in it.
    always_ff @(posedge clk) begin
        if (rst) init_q <= 1'b1;
        else     init_q <= 1'b0;
    end

    // Priority: memory wait, then redirect, then data stall.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        fwd_rs1     = FWD_RF;
        fwd_rs2     = FWD_RF;
        if (active) begin
            fwd_rs1 = sel1;
            fwd_rs2 = sel2;
            if (busy) begin
                pipe_freeze = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
            end else if (redir) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (data_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    // Advance the shadow with the real pipe; a bubble enters EX on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ex  <= '0;
            s_mem <= '0;
            s_wb  <= '0;
        end else if (!busy) begin
            s_wb  <= s_mem;
            s_mem <= ex_tag;
            if (idex_flush) s_ex <= '0;
            else            s_ex <= {id_valid, id_rd, id_we, id_is_load};
        end
    end

    // Saturating performance counters; a redirect supersedes the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (data_stall && !redir && !busy) stall_q <= sat_inc(stall_q);
            if (redir && !busy)                flush_q <= sat_inc(flush_q);
        end
    end

    assign stall_cnt = rst ? '0 : stall_q;
    assign flush_cnt = rst ? '0 : flush_q;

endmodule
